priority_arbiter_rr: RTL

//  Parametrised, registered successor to the 16-input priority encoder. It picks one of N

---
 rtl/priority_arbiter_rr.sv | 99 +++++++++
 1 files changed

// File: rtl/priority_arbiter_rr.sv
// Registered N-way arbiter with valid/ready grant handshake.
// Fixed priority (highest index wins) or round-robin rotation from the last accepted grant.
module priority_arbiter_rr #(
   parameter int N = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 rr_mode,
   input  logic [N-1:0]         req,
   input  logic                 grant_ready,
   output logic                 grant_valid,
   output logic [$clog2(N)-1:0] grant_idx,
   output logic [N-1:0]         grant_onehot
);
   localparam int W = $clog2(N);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t         state_q;
   logic           valid_q;
   logic [W-1:0]   idx_q;
   logic [N-1:0]   onehot_q;
   logic [W-1:0]   ptr_q;

   logic           accept;
   logic [W-1:0]   ptr_sel;
   logic [W-1:0]   start;
   logic           win_found;
   logic [W-1:0]   win_idx_d;
   logic [N-1:0]   win_onehot_d;
   int             pos;

   // On accept the next winner is searched from the grant being retired, not the stale ptr.
   always_comb begin
      accept       = valid_q & grant_ready;
      ptr_sel      = accept ? idx_q : ptr_q;
      start        = rr_mode ? ptr_sel : '0;
      win_found    = 1'b0;
      win_idx_d    = '0;
      pos          = 0;
      for (int k = 1; k <= N; k++) begin
         pos = int'(start) + N - k;
         if (pos >= N) pos = pos - N;
         if (!win_found && req[W'(pos)]) begin
            win_found = 1'b1;
            win_idx_d = W'(pos);
         end
      end
      win_onehot_d = N'(1) << win_idx_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         valid_q  <= 1'b0;
         idx_q    <= '0;
         onehot_q <= '0;
         ptr_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (en && win_found) begin
                  state_q  <= GRANT;
                  valid_q  <= 1'b1;
                  idx_q    <= win_idx_d;
                  onehot_q <= win_onehot_d;
               end
            end
            GRANT: begin
               // Held grant stays frozen until the consumer takes it.
               if (grant_ready) begin
                  ptr_q <= idx_q;
                  if (en && win_found) begin
                     idx_q    <= win_idx_d;
                     onehot_q <= win_onehot_d;
                  end else begin
                     state_q  <= IDLE;
                     valid_q  <= 1'b0;
                     idx_q    <= '0;
                     onehot_q <= '0;
                  end
               end
            end
            default: begin
               state_q  <= IDLE;
               valid_q  <= 1'b0;
               idx_q    <= '0;
               onehot_q <= '0;
            end
         endcase
      end
   end

   assign grant_valid  = valid_q;
   assign grant_idx    = idx_q;
   assign grant_onehot = onehot_q;

endmodule
